// File: rtl/uart_point_decoder_pkg.sv
// Shared types and constants for the UART point deframer.
// Record byte offsets, field widths and the FIFO entry layout.
package uart_point_decoder_pkg;

  localparam int COORD_W = 12;
  localparam int COLOR_W = 8;
  localparam int ENTRY_W = 1 + COLOR_W + 2 * COORD_W;

  // byte position of each field within a 4-byte record
  localparam int B_X_HI  = 0;
  localparam int B_XY    = 1;
  localparam int B_Y_LO  = 2;
  localparam int B_COLOR = 3;

  typedef enum logic [1:0] {
    IDX0,
    IDX1,
    IDX2,
    IDX3
  } idx_e;

  // FIFO entry layout: {frame, color, Y, X}
  typedef struct packed {
    logic               frame;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

  // an all-zero record is a frame marker, not a drawable point
  function automatic point_t make_point(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COLOR_W-1:0] color
  );
    point_t p;
    p.x     = x;
    p.y     = y;
    p.color = color;
    p.frame = (x == '0) && (y == '0) && (color == '0);
    return p;
  endfunction

endpackage

// File: rtl/uart_point_decoder_point_fifo.sv
// Synchronous FIFO with flop-held head and full/empty flags.
// Ports: i_Clock, i_Reset, write (i_Wr_En/i_Wr_Data), read (i_Rd_En/o_Rd_Data), o_Full, o_Empty.
module point_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Wr_En,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign o_Full  = (count == (AW+1)'(DEPTH));
  assign o_Empty = (count == '0);

  // a pop in the same cycle frees a slot, so a full FIFO may still accept
  assign do_rd = i_Rd_En && !o_Empty;
  assign do_wr = i_Wr_En && (!o_Full || do_rd);

  // head reads as zero while empty so stale entries never leak out
  assign o_Rd_Data = o_Empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= i_Wr_Data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_point_decoder.sv
// Deframes UART byte strobes into 4-byte X/Y/color point records and queues them.
// Ports: i_Clock, i_Reset, i_Rx_DV/i_Rx_Byte in; point head + valid/ready, o_Overflow, o_Resync out.
// Macro UART_POINT_TIMEOUT_EN enables the mid-record idle timeout and o_Resync.
module uart_point_decoder
  import uart_point_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Rx_DV,
  input  logic [7:0]         i_Rx_Byte,
  output logic               o_Point_Valid,
  input  logic               i_Point_Ready,
  output logic [COORD_W-1:0] o_Point_X,
  output logic [COORD_W-1:0] o_Point_Y,
  output logic [COLOR_W-1:0] o_Point_Color,
  output logic               o_Point_Frame,
  output logic               o_Overflow,
  output logic               o_Resync
);

  idx_e       idx;
  logic [7:0] rec [4];
  logic       overflow_q;
  logic       timeout_hit;

  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  point_t     new_pt;
  point_t     head;

  assign push = i_Rx_DV && (idx == IDX3);
  assign pop  = o_Point_Valid && i_Point_Ready;

  // the fourth byte is taken straight from the bus so it lands this edge
  assign new_pt = make_point(
    {rec[B_X_HI], rec[B_XY][7:4]},
    {rec[B_XY][3:0], rec[B_Y_LO]},
    i_Rx_Byte
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      idx        <= IDX0;
      rec        <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      // a byte arriving on the timeout cycle keeps the record alive
      if (i_Rx_DV) begin
        rec[idx] <= i_Rx_Byte;
        idx      <= idx_e'(idx + 2'd1);
      end else if (timeout_hit) begin
        idx <= IDX0;
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef UART_POINT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  logic [CW-1:0] idle_cnt;
  logic          resync_q;

  // fires on the edge where the idle count would reach TIMEOUT_CLKS
  assign timeout_hit = (idx != IDX0) && !i_Rx_DV &&
                       (idle_cnt == CW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      idle_cnt <= '0;
      resync_q <= 1'b0;
    end else begin
      resync_q <= timeout_hit;
      if (i_Rx_DV || (idx == IDX0) || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign o_Resync = resync_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CLKS;
  assign timeout_hit        = 1'b0;
  assign o_Resync           = 1'b0;
`endif

  point_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Wr_En   (push),
    .i_Wr_Data (new_pt),
    .i_Rd_En   (pop),
    .o_Rd_Data (head),
    .o_Full    (full),
    .o_Empty   (empty)
  );

  assign o_Point_Valid = !empty;
  assign o_Point_X     = head.x;
  assign o_Point_Y     = head.y;
  assign o_Point_Color = head.color;
  assign o_Point_Frame = head.frame;
  assign o_Overflow    = overflow_q;

endmodule
